ram_1w2r: RTL and testbench

- Memory with one write port and two independent read ports.
- Serves cache lookup paths that need two valid-bit or tag reads per cycle, for example a fetch read and a snoop read.
- Built from two identical 1W1R block-RAM banks. Every write updates both banks, and each read port owns one bank.
- Adds write-first forwarding so same-cycle reads see new data, and an invalidate-all sweep engine that zeroes the array after reset or on request.

---
 rtl/ram_1w2r.sv | 113 +++++++++++
 tb/tb_ram_1w2r.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ram_1w2r.sv
// Two-read, one-write RAM built from two mirrored 1W1R banks, with write-first
// forwarding and an invalidate-all sweep that zeroes the array after reset or on request.
module ram_1w2r #(
   parameter int WIDTH  = 1,
   parameter int DEEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DEEPTH-1:0] W_addr,
   input  logic [WIDTH-1:0]  W_data,
   input  logic              W_en,
   input  logic [DEEPTH-1:0] R_addr_A,
   input  logic              R_en_A,
   output logic [WIDTH-1:0]  R_data_A,
   input  logic [DEEPTH-1:0] R_addr_B,
   input  logic              R_en_B,
   output logic [WIDTH-1:0]  R_data_B,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   // state | meaning
   // IDLE  | normal operation: writes land in both banks, reads see bank or forwarded data
   // CLEAR | sweep zeroes entry ptr each cycle; writes dropped, reads return 0
   typedef enum logic {IDLE, CLEAR} state_t;

   localparam int N = 2**DEEPTH;

   state_t            state, state_nxt;
   logic [DEEPTH-1:0] ptr, ptr_nxt;
   logic              done_nxt;
   logic              busy;
   logic              wr_live;

   logic [WIDTH-1:0]  bank_a [N];
   logic [WIDTH-1:0]  bank_b [N];

   assign busy     = (state == CLEAR);
   assign wr_live  = W_en && !busy;
   assign clr_busy = busy;

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               ptr_nxt   = '0;
            end
         end
         CLEAR: begin
            ptr_nxt = ptr + DEEPTH'(1);
            if (&ptr) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= CLEAR;
         ptr      <= '0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         clr_done <= done_nxt;
      end
   end

   // Banks carry no reset; the sweep is what initialises contents.
   always_ff @(posedge clk) begin
      if (busy) begin
         bank_a[ptr] <= '0;
         bank_b[ptr] <= '0;
      end else if (W_en) begin
         bank_a[W_addr] <= W_data;
         bank_b[W_addr] <= W_data;
      end
   end

   // Precedence: sweep-zero, then same-edge write forward, then bank contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         R_data_A <= '0;
         R_data_B <= '0;
      end else begin
         if (R_en_A) begin
            if (busy)
               R_data_A <= '0;
            else if (wr_live && (W_addr == R_addr_A))
               R_data_A <= W_data;
            else
               R_data_A <= bank_a[R_addr_A];
         end
         if (R_en_B) begin
            if (busy)
               R_data_B <= '0;
            else if (wr_live && (W_addr == R_addr_B))
               R_data_B <= W_data;
            else
               R_data_B <= bank_b[R_addr_B];
         end
      end
   end

endmodule

// File: tb/tb_ram_1w2r.sv
// Scoreboard bench for ram_1w2r: a plain array/counter model predicts every cycle,
// a negedge monitor pops predictions and compares them with the DUT outputs.
module tb_ram_1w2r;
   localparam int WIDTH  = 4;
   localparam int DEEPTH = 3;
   localparam int N      = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DEEPTH-1:0] W_addr = '0;
   logic [WIDTH-1:0]  W_data = '0;
   logic              W_en = 1'b0;
   logic [DEEPTH-1:0] R_addr_A = '0;
   logic              R_en_A = 1'b0;
   logic [WIDTH-1:0]  R_data_A;
   logic [DEEPTH-1:0] R_addr_B = '0;
   logic              R_en_B = 1'b0;
   logic [WIDTH-1:0]  R_data_B;
   logic              clr_req = 1'b0;
   logic              clr_busy;
   logic              clr_done;

   ram_1w2r #(.WIDTH(WIDTH), .DEEPTH(DEEPTH)) dut (
      .clk(clk), .rst(rst),
      .W_addr(W_addr), .W_data(W_data), .W_en(W_en),
      .R_addr_A(R_addr_A), .R_en_A(R_en_A), .R_data_A(R_data_A),
      .R_addr_B(R_addr_B), .R_en_B(R_en_B), .R_data_B(R_data_B),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             busy;
      logic             done;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;

   // reference model: memory contents, sweep cycles remaining, held read values
   logic [WIDTH-1:0] mem [N];
   int               clr_left;
   logic [WIDTH-1:0] ra, rb;
   logic             dn;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp_v);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         chk("R_data_A", 32'(R_data_A), 32'(mon_e.a));
         chk("R_data_B", 32'(R_data_B), 32'(mon_e.b));
         chk("clr_busy", 32'(clr_busy), 32'(mon_e.busy));
         chk("clr_done", 32'(clr_done), 32'(mon_e.done));
      end
   end

   task automatic step(input logic we, input logic [DEEPTH-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic rea, input logic [DEEPTH-1:0] aa,
                       input logic reb, input logic [DEEPTH-1:0] ab, input logic cr);
      exp_t e;
      bit   busy_now;
      W_en = we; W_addr = wa; W_data = wd;
      R_en_A = rea; R_addr_A = aa; R_en_B = reb; R_addr_B = ab;
      clr_req = cr;
      @(posedge clk);
      busy_now = (clr_left > 0);
      if (rea) ra = busy_now ? '0 : ((we && wa == aa) ? wd : mem[aa]);
      if (reb) rb = busy_now ? '0 : ((we && wa == ab) ? wd : mem[ab]);
      dn = 1'b0;
      if (busy_now) begin
         mem[N - clr_left] = '0;
         clr_left--;
         if (clr_left == 0) dn = 1'b1;
      end else begin
         if (we) mem[wa] = wd;
         if (cr) clr_left = N;
      end
      e.a = ra; e.b = rb; e.busy = (clr_left > 0); e.done = dn;
      sb.push_back(e);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, '0, 0);
   endtask

   task automatic wr(input logic [DEEPTH-1:0] a, input logic [WIDTH-1:0] d);
      step(1, a, d, 0, '0, 0, '0, 0);
   endtask

   task automatic rd_all();
      for (int i = 0; i < N; i++)
         step(0, '0, '0, 1, DEEPTH'(i), 1, DEEPTH'(N - 1 - i), 0);
   endtask

   // Asserts rst between edges, checks the immediate effect, then releases after two edges.
   task automatic do_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_R_data_A", 32'(R_data_A), 32'h0);
      chk("rst_R_data_B", 32'(R_data_B), 32'h0);
      chk("rst_clr_done", 32'(clr_done), 32'h0);
      chk("rst_clr_busy", 32'(clr_busy), 32'h1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clr_left = N; ra = '0; rb = '0; dn = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) mem[i] = '0;
      ra = '0; rb = '0; dn = 1'b0; clr_left = N;

      // initial reset
      repeat (2) @(posedge clk);
      #1;
      chk("init_R_data_A", 32'(R_data_A), 32'h0);
      chk("init_R_data_B", 32'(R_data_B), 32'h0);
      chk("init_clr_done", 32'(clr_done), 32'h0);
      chk("init_clr_busy", 32'(clr_busy), 32'h1);
      rst = 1'b0;

      // sweep after reset release, then read addr 5
      idle(10);
      step(0, '0, '0, 1, 3'd5, 0, '0, 0);

      // write then dual read; hold through a later write
      wr(3'd3, 4'h1);
      step(0, '0, '0, 1, 3'd3, 1, 3'd3, 0);
      wr(3'd3, 4'h0);
      idle(2);

      // same-edge forward on A, untouched addr on B
      step(1, 3'd6, 4'h1, 1, 3'd6, 1, 3'd2, 0);
      idle(1);

      // requested sweep with writes/reads/extra request during busy
      for (int i = 0; i < N; i++) wr(DEEPTH'(i), 4'h1);
      step(0, '0, '0, 0, '0, 0, '0, 1);
      for (int i = 0; i < N; i++) step(1, 3'd4, 4'h1, 1, 3'd7, 0, '0, (i == 2));
      idle(2);
      rd_all();

      // reset in the middle of a sweep
      for (int i = 0; i < N; i++) wr(DEEPTH'(i), 4'hF);
      rd_all();
      step(0, '0, '0, 0, '0, 0, '0, 1);
      for (int i = 0; i < 4; i++) step(0, '0, '0, 1, DEEPTH'(i), 1, DEEPTH'(i), 0);
      do_reset();
      idle(10);
      rd_all();

      // clr_req with same-edge write and forwarded read
      step(1, 3'd1, 4'h1, 1, 3'd1, 0, '0, 1);
      idle(9);
      step(0, '0, '0, 1, 3'd1, 1, 3'd1, 0);

      // randomized traffic with occasional sweep requests
      for (int i = 0; i < 400; i++)
         step(1'($urandom), DEEPTH'($urandom), WIDTH'($urandom),
              1'($urandom), DEEPTH'($urandom), 1'($urandom), DEEPTH'($urandom),
              ($urandom_range(0, 24) == 0));
      rd_all();

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
